// File: rtl/m_ifetch_queue.sv
// Instruction-fetch front end. It owns the fetch PC and issues reads to a
// one-cycle-latency instruction memory. Returned words are queued together
// with their PCs and handed to decode over a valid/ready handshake. A
// redirect flushes the queue and restarts fetch at a new PC.
module m_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clock,
    input  logic        w_rst_n,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic [31:0] w_imem_rdata,
    output logic        w_valid,
    output logic [31:0] w_ir,
    output logic [31:0] w_pc,
    input  logic        w_ready,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t         q_mem [DEPTH];
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    issue_pc_q, issue_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           inflight_q, inflight_d;
    logic           drop_q, drop_d;
    logic [CW:0]    occupancy;
    logic           push, pop;

    // Entries held plus the one that may still be returning; a new request
    // is issued only when a slot is guaranteed for its data.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign w_imem_req  = w_rst_n & ~w_redirect & (occupancy < (CW+1)'(DEPTH));
    assign w_imem_addr = fetch_pc_q;

    // A response that lands during a redirect, or belongs to a flushed
    // request, is thrown away.
    assign push    = inflight_q & ~drop_q & ~w_redirect;
    assign pop     = w_valid & w_ready;
    assign w_valid = w_rst_n & (count_q != '0);
    assign w_ir    = w_valid ? q_mem[rd_ptr_q].ir : 32'h0;
    assign w_pc    = w_valid ? q_mem[rd_ptr_q].pc : 32'h0;

    // Next-state: redirect flushes everything, otherwise push/pop/issue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = w_imem_req;
        drop_d     = 1'b0;
        if (w_imem_req) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            issue_pc_d = fetch_pc_q;
        end
        if (w_redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {w_redirect_pc[31:2], 2'b00};
            drop_d     = inflight_q | w_imem_req;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge w_clock) begin
        if (!w_rst_n) begin
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Queue storage; contents need no reset since count gates visibility.
    always_ff @(posedge w_clock) begin
        if (w_rst_n && push) q_mem[wr_ptr_q] <= '{ir: w_imem_rdata, pc: issue_pc_q};
    end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Directed bench for m_ifetch_queue: latency, back-pressure, redirect,
// PC wrap, mid-stream reset and a randomised ready scoreboard.
module tb_m_ifetch_queue;

    logic        gclk = 1'b0;
    logic        grst_n;
    logic        ready, redirect;
    logic [31:0] redirect_pc;
    logic        req, req2, valid, valid2;
    logic [31:0] addr, addr2, rdata, rdata2, ir, ir2, pc, pc2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 gclk = ~gclk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // One-cycle-latency instruction memories.
    always @(posedge gclk) if (req)  rdata  <= word(addr);
    always @(posedge gclk) if (req2) rdata2 <= word(addr2);

    m_ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .w_clock(gclk), .w_rst_n(grst_n), .w_imem_req(req), .w_imem_addr(addr),
        .w_imem_rdata(rdata), .w_valid(valid), .w_ir(ir), .w_pc(pc),
        .w_ready(ready), .w_redirect(redirect), .w_redirect_pc(redirect_pc));

    m_ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .w_clock(gclk), .w_rst_n(grst_n), .w_imem_req(req2), .w_imem_addr(addr2),
        .w_imem_rdata(rdata2), .w_valid(valid2), .w_ir(ir2), .w_pc(pc2),
        .w_ready(ready), .w_redirect(redirect), .w_redirect_pc(redirect_pc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic nxt();
        @(posedge gclk);
        #1;
    endtask

    // Two reset edges, then release; returns at cycle 0 with inputs applied.
    task automatic do_reset(input logic rdy);
        grst_n = 1'b0; ready = rdy; redirect = 1'b0; redirect_pc = '0;
        nxt(); nxt();
        grst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc, prev_pc, prev_ir;
        logic        hold;

        // ---- reset state ----
        grst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        nxt(); #1;
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pc, 32'h0);

        // ---- streaming with ready=1; dut2 shows PC wrap ----
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("s_req%0d", c), {31'b0, req}, 32'd1);
            chk($sformatf("s_addr%0d", c), addr, 32'(4 * c));
            if (c < 2) chk($sformatf("s_nv%0d", c), {31'b0, valid}, 32'd0);
            else begin
                chk($sformatf("s_v%0d", c), {31'b0, valid}, 32'd1);
                chk($sformatf("s_pc%0d", c), pc, 32'(4 * (c - 2)));
                chk($sformatf("s_ir%0d", c), ir, 32'h1000_0000 + 32'(c - 2));
            end
            if (c >= 2 && c <= 5) begin
                chk($sformatf("w_v%0d", c), {31'b0, valid2}, 32'd1);
                chk($sformatf("w_pc%0d", c), pc2, 32'hFFFF_FFF8 + 32'(4 * (c - 2)));
            end
            nxt();
        end

        // ---- back-pressure from reset ----
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                chk($sformatf("f_req%0d", c), {31'b0, req}, 32'd1);
                chk($sformatf("f_addr%0d", c), addr, 32'(4 * c));
            end else begin
                chk($sformatf("f_noreq%0d", c), {31'b0, req}, 32'd0);
                chk($sformatf("f_head%0d", c), pc, 32'h0);
            end
            nxt();
        end
        ready = 1'b1; #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("d_v%0d", c), {31'b0, valid}, 32'd1);
            chk($sformatf("d_pc%0d", c), pc, 32'(4 * c));
            nxt();
        end

        // ---- redirect with 3 queued and one in flight ----
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) nxt();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("r_req_during", {31'b0, req}, 32'd0);
        nxt();
        redirect = 1'b0; ready = 1'b1; #1;
        chk("r_v_after", {31'b0, valid}, 32'd0);
        chk("r_req_after", {31'b0, req}, 32'd1);
        chk("r_addr_after", addr, 32'h100);
        nxt(); #1;
        chk("r_v_c2", {31'b0, valid}, 32'd0);
        nxt(); #1;
        chk("r_v_first", {31'b0, valid}, 32'd1);
        chk("r_pc_first", pc, 32'h100);
        chk("r_ir_first", ir, 32'h1000_0040);
        nxt(); #1;
        chk("r_pc_second", pc, 32'h104);

        // ---- back-to-back redirects: last wins ----
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        nxt();
        redirect_pc = 32'h302; #1;
        chk("bb_v", {31'b0, valid}, 32'd0);
        nxt();
        redirect = 1'b0; #1;
        chk("bb_v2", {31'b0, valid}, 32'd0);
        chk("bb_addr", addr, 32'h300);
        nxt(); nxt(); #1;
        chk("bb_pc", pc, 32'h300);

        // ---- reset mid-stream ----
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) nxt();
        grst_n = 1'b0; #1;
        chk("mr_v", {31'b0, valid}, 32'd0);
        chk("mr_req", {31'b0, req}, 32'd0);
        nxt();
        grst_n = 1'b1; ready = 1'b1; #1;
        chk("mr_addr0", addr, 32'h0);
        chk("mr_v0", {31'b0, valid}, 32'd0);
        nxt(); #1;
        chk("mr_v1", {31'b0, valid}, 32'd0);
        nxt(); #1;
        chk("mr_pc", pc, 32'h0);
        chk("mr_ir", ir, 32'h1000_0000);

        // ---- random ready scoreboard ----
        do_reset(1'b0);
        exp_pc = 32'h0; hold = 1'b0; prev_pc = '0; prev_ir = '0;
        for (int c = 0; c < 200; c++) begin
            ready = 1'($urandom_range(0, 1)); #1;
            if (hold) begin
                chk("rnd_hold_pc", pc, prev_pc);
                chk("rnd_hold_ir", ir, prev_ir);
            end
            if (valid) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_ir", ir, word(exp_pc));
                if (ready) exp_pc = exp_pc + 32'd4;
            end
            hold = valid & ~ready; prev_pc = pc; prev_ir = ir;
            nxt();
        end
        chk("rnd_progress", {31'b0, (exp_pc > 32'd160)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/m_ifetch_queue.md
Name: m_ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/execute datapath.
- Owns the fetch PC and drives a synchronous instruction memory with a fixed one-cycle read latency.
- Buffers returned instructions, tagged with their PCs, in a small FIFO.
- Presents them to decode over a valid/ready handshake, and supports a redirect that flushes the queue and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- w_clock  input  1  rising-edge clock
- w_rst_n  input  1  synchronous reset, active-low
- w_imem_req  output  1  memory read request this cycle
- w_imem_addr  output  32  read address; valid when w_imem_req=1
- w_imem_rdata  input  32  read data, valid the cycle after an accepted request
- w_valid  output  1  queue head holds an instruction
- w_ir  output  32  head instruction
- w_pc  output  32  PC of head instruction
- w_ready  input  1  decode accepts head this cycle
- w_redirect  input  1  flush and restart fetch
- w_redirect_pc  input  32  new fetch PC; bits [1:0] are forced to 0

Behaviour:
- Reset, sampled on a clock edge with w_rst_n=0:
  - r_fetch_pc=RESET_PC, queue count=0, read/write pointers=0, r_inflight=0, r_drop=0.
  - While w_rst_n=0: w_imem_req=0, w_valid=0, w_ir=0, w_pc=0.
  - Reset has priority over every other input, including mid-fetch and mid-redirect.
- Issue rule (combinational from registered state):
  - w_imem_req = w_rst_n & !w_redirect & (count + r_inflight < DEPTH).
  - w_imem_addr = r_fetch_pc.
  - On an edge with w_imem_req=1: r_fetch_pc += 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0), and r_inflight <= 1. Otherwise r_inflight <= 0.
- Return:
  - In a cycle with r_inflight=1 and r_drop=0, {w_imem_rdata, r_issue_pc} is written at the tail on that edge.
  - r_issue_pc is the address issued in the previous cycle.
  - The issue rule guarantees a free slot, so a write never overflows.
- Dequeue: on an edge with w_valid & w_ready, the head pops.
- Simultaneous push and pop: count is unchanged and both pointers advance; both wrap modulo DEPTH.
- Output timing:
  - w_valid = (count != 0). w_ir and w_pc are driven from the head entry.
  - While w_valid=1 and w_ready=0, w_ir and w_pc stay stable.
- Latency:
  - Request in cycle N, data in the queue at the end of N+1, w_valid=1 in N+2.
  - Steady-state throughput is 1 instruction/cycle with w_ready held high.
- Redirect (w_redirect=1 on an edge, w_rst_n=1):
  - Count=0 and pointers=0; any pop that cycle is discarded.
  - r_fetch_pc <= {w_redirect_pc[31:2], 2'b00}.
  - r_drop <= r_inflight | w_imem_req. Because w_imem_req is forced to 0 during a redirect, this equals r_inflight.
  - Any response arriving in the redirect cycle is discarded.
  - The cycle after: w_valid=0, w_imem_req=1 with the redirect address. r_drop clears after the next edge.
- Back-to-back redirects: the last one wins. The queue stays empty throughout.
- Full queue with w_ready=0: w_imem_req=0, no fetch PC change, and no lost or duplicated instructions.

Test Plan:
- Reset release, memory word k = 32'h1000_0000+k at address 4k, w_ready=1 -> requests at 0,4,8,... from cycle 0; w_valid rises in cycle 2 with w_pc=0, w_ir=32'h1000_0000; one instruction per cycle thereafter, in order.
- w_ready=0 from reset (DEPTH=4) -> exactly 4 requests (addrs 0..12) then w_imem_req=0. Then w_ready=1 for 6 cycles -> PCs 0,4,8,12,16,20 with no gaps after the first.
- Redirect to 32'h0000_0103 while the queue holds 3 entries and a request is in flight -> next cycle w_valid=0 and w_imem_addr=32'h100. The in-flight response is never output. First delivered PC is 32'h100, two cycles later.
- RESET_PC=32'hFFFF_FFF8, w_ready=1 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert w_rst_n=0 for 1 cycle mid-stream with the queue partly full -> w_valid=0 and w_imem_req=0 in that cycle. Fetch resumes at RESET_PC with none of the old entries delivered.
- Random w_ready toggling over 200 cycles -> a scoreboard sees a gap-free, duplicate-free PC sequence. w_ir/w_pc stay stable whenever w_valid=1 and w_ready=0.
